line_buffer_ctrl: RTL and testbench

Sequencer for the stack of row-bank memories that form the vertical line buffer of the separable convolution. It accepts a raster pixel stream and drives shared address and read-enable signals plus one write-enable per bank. Each new row overwrites the bank holding the oldest row, so the banks act as a circular row store. It emits a delayed pixel, aligned to the one-cycle bank read latency, together with window-valid and row-order metadata for the vertical filter stage.

---
 rtl/line_buffer_ctrl.sv | 91 +++++++++
 tb/tb_line_buffer_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// Row-bank sequencer for the vertical line buffer: circular row store over KERNEL-1 banks.
// Bank drive is combinational; window outputs are registered one cycle later. No backpressure.
module line_buffer_ctrl #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 640,
  parameter  int KERNEL = 3,
  localparam int NB     = KERNEL - 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int SW     = (NB > 2) ? $clog2(NB) : 1,
  localparam int RW     = $clog2(NB + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [WIDTH-1:0] i_pixel,
  output logic [NB-1:0]    o_bank_we,
  output logic             o_bank_re,
  output logic [AW-1:0]    o_bank_addr,
  output logic [WIDTH-1:0] o_bank_wdata,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_pixel,
  output logic [SW-1:0]    o_oldest,
  output logic [AW-1:0]    o_col,
  output logic             o_eol,
  output logic             o_primed
);

  typedef enum logic {FILL, RUN} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   col, c;
  logic [SW-1:0]   wr_sel, b, b_next;
  logic [RW-1:0]   rows, rows_base, rows_inc;
  logic            accepted, last_col, win;

  always_comb begin
    accepted   = i_valid & ~i_rst;
    c          = i_sof ? '0 : col;
    b          = i_sof ? '0 : wr_sel;
    rows_base  = i_sof ? '0 : rows;
    last_col   = (c == AW'(DEPTH - 1));
    b_next     = (b == SW'(NB - 1)) ? '0 : b + 1'b1;
    rows_inc   = (rows_base == RW'(NB)) ? rows_base : rows_base + 1'b1;
    // A start-of-frame pixel never sees the old frame's window.
    win        = accepted && (state == RUN) && !i_sof;
    state_next = i_sof ? FILL : state;
    if (last_col && rows_inc == RW'(NB))
      state_next = RUN;

    o_bank_re    = accepted;
    o_bank_addr  = c;
    o_bank_we    = accepted ? (NB'(1) << b) : '0;
    o_bank_wdata = i_pixel;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= FILL;
      col      <= '0;
      wr_sel   <= '0;
      rows     <= '0;
      o_valid  <= 1'b0;
      o_pixel  <= '0;
      o_oldest <= '0;
      o_col    <= '0;
      o_eol    <= 1'b0;
      o_primed <= 1'b0;
    end else begin
      o_valid <= win;
      o_eol   <= accepted && last_col;
      if (accepted) begin
        o_pixel  <= i_pixel;
        o_oldest <= b;
        o_col    <= c;
        state    <= state_next;
        o_primed <= (state_next == RUN);
        if (!last_col) begin
          col    <= c + 1'b1;
          wr_sel <= b;
          rows   <= rows_base;
        end else begin
          col    <= '0;
          wr_sel <= b_next;
          rows   <= rows_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Table-driven bench for line_buffer_ctrl with a behavioural row-bank model (read-old-data).
module tb_line_buffer_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int KERNEL = 3;
  localparam int NB = KERNEL - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, valid = 1'b1, sof = 1'b0;
  logic [7:0] pixel = 8'd55;
  logic [1:0] bank_we;
  logic bank_re;
  logic [1:0] bank_addr;
  logic [7:0] bank_wdata;
  logic o_valid;
  logic [7:0] o_pixel;
  logic o_oldest;
  logic [1:0] o_col;
  logic o_eol, o_primed;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .KERNEL(KERNEL)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof), .i_pixel(pixel),
    .o_bank_we(bank_we), .o_bank_re(bank_re), .o_bank_addr(bank_addr),
    .o_bank_wdata(bank_wdata), .o_valid(o_valid), .o_pixel(o_pixel),
    .o_oldest(o_oldest), .o_col(o_col), .o_eol(o_eol), .o_primed(o_primed)
  );

  // Row banks: one-cycle read latency, read returns the word before a same-cycle write.
  logic [7:0] mem [NB][DEPTH];
  logic [7:0] rd [NB];
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (bank_re) rd[k] <= mem[k][bank_addr];
      if (bank_we[k]) mem[k][bank_addr] <= bank_wdata;
    end
  end

  typedef struct {
    logic       rst, v, sof;
    logic [7:0] pix;
    logic [1:0] we, addr;
    logic       ov;
    logic [7:0] opix;
    logic [1:0] ocol;
    logic       oeol, oold, oprim;
    logic       chk_rd;
    logic [7:0] d0, d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic s, logic [7:0] p, logic [1:0] we,
                              logic [1:0] ad, logic ov, logic [7:0] op, logic [1:0] oc,
                              logic oe, logic oo, logic opr);
    vec_t t;
    t.rst = r; t.v = v; t.sof = s; t.pix = p; t.we = we; t.addr = ad;
    t.ov = ov; t.opix = op; t.ocol = oc; t.oeol = oe; t.oold = oo; t.oprim = opr;
    t.chk_rd = 1'b0; t.d0 = '0; t.d1 = '0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    rst = t.rst; valid = t.v; sof = t.sof; pixel = t.pix;
    #1;
    chk({tag, ".we"}, 32'(bank_we), 32'(t.we));
    chk({tag, ".re"}, 32'(bank_re), 32'(t.v & ~t.rst));
    if (!t.rst) begin
      chk({tag, ".addr"}, 32'(bank_addr), 32'(t.addr));
      chk({tag, ".wdata"}, 32'(bank_wdata), 32'(t.pix));
    end
    @(posedge clk);
    #1;
    chk({tag, ".ovalid"}, 32'(o_valid), 32'(t.ov));
    chk({tag, ".opixel"}, 32'(o_pixel), 32'(t.opix));
    chk({tag, ".ocol"}, 32'(o_col), 32'(t.ocol));
    chk({tag, ".oeol"}, 32'(o_eol), 32'(t.oeol));
    chk({tag, ".oldest"}, 32'(o_oldest), 32'(t.oold));
    chk({tag, ".primed"}, 32'(o_primed), 32'(t.oprim));
    if (t.chk_rd) begin
      chk({tag, ".bank0"}, 32'(rd[0]), 32'(t.d0));
      chk({tag, ".bank1"}, 32'(rd[1]), 32'(t.d1));
    end
  endtask

  initial begin
    vec_t t;
    // reset held two cycles with valid high
    vecs.push_back(mk(1,1,0,8'd55, 2'b00,0, 0,8'd0,0,0,0,0));
    vecs.push_back(mk(1,1,0,8'd56, 2'b00,0, 0,8'd0,0,0,0,0));
    // fill: row 1 in bank 0, row 2 in bank 1
    vecs.push_back(mk(0,1,1,8'd1, 2'b01,0, 0,8'd1,0,0,0,0));
    vecs.push_back(mk(0,1,0,8'd2, 2'b01,1, 0,8'd2,1,0,0,0));
    vecs.push_back(mk(0,1,0,8'd3, 2'b01,2, 0,8'd3,2,0,0,0));
    vecs.push_back(mk(0,1,0,8'd4, 2'b01,3, 0,8'd4,3,1,0,0));
    vecs.push_back(mk(0,1,0,8'd5, 2'b10,0, 0,8'd5,0,0,1,0));
    vecs.push_back(mk(0,1,0,8'd6, 2'b10,1, 0,8'd6,1,0,1,0));
    vecs.push_back(mk(0,1,0,8'd7, 2'b10,2, 0,8'd7,2,0,1,0));
    vecs.push_back(mk(0,1,0,8'd8, 2'b10,3, 0,8'd8,3,1,1,1));
    // run: pixel 9 sees rows 1 and 2
    t = mk(0,1,0,8'd9, 2'b01,0, 1,8'd9,0,0,0,1);
    t.chk_rd = 1; t.d0 = 8'd1; t.d1 = 8'd5;
    vecs.push_back(t);
    vecs.push_back(mk(0,1,0,8'd10, 2'b01,1, 1,8'd10,1,0,0,1));
    vecs.push_back(mk(0,1,0,8'd11, 2'b01,2, 1,8'd11,2,0,0,1));
    vecs.push_back(mk(0,1,0,8'd12, 2'b01,3, 1,8'd12,3,1,0,1));
    t = mk(0,1,0,8'd13, 2'b10,0, 1,8'd13,0,0,1,1);
    t.chk_rd = 1; t.d0 = 8'd9; t.d1 = 8'd5;
    vecs.push_back(t);
    // gaps: valid pattern 1,0,0,1
    vecs.push_back(mk(0,1,0,8'd14, 2'b10,1, 1,8'd14,1,0,1,1));
    vecs.push_back(mk(0,0,0,8'd99, 2'b00,2, 0,8'd14,1,0,1,1));
    vecs.push_back(mk(0,0,0,8'd98, 2'b00,2, 0,8'd14,1,0,1,1));
    vecs.push_back(mk(0,1,0,8'd15, 2'b10,2, 1,8'd15,2,0,1,1));
    vecs.push_back(mk(0,1,0,8'd16, 2'b10,3, 1,8'd16,3,1,1,1));
    vecs.push_back(mk(0,1,0,8'd17, 2'b01,0, 1,8'd17,0,0,0,1));
    vecs.push_back(mk(0,1,0,8'd18, 2'b01,1, 1,8'd18,1,0,0,1));
    // sof mid-row at col 2: restart at bank 0 address 0
    vecs.push_back(mk(0,1,1,8'd19, 2'b01,0, 0,8'd19,0,0,0,0));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(0,1,0,8'(19+i), (i < 4) ? 2'b01 : 2'b10, 2'(i % 4),
                        0, 8'(19+i), 2'(i % 4), (i % 4) == 3, i >= 4, i == 7));
    // ninth pixel after sof is the first valid window
    vecs.push_back(mk(0,1,0,8'd27, 2'b01,0, 1,8'd27,0,0,0,1));
    vecs.push_back(mk(0,1,0,8'd28, 2'b01,1, 1,8'd28,1,0,0,1));
    vecs.push_back(mk(0,1,0,8'd29, 2'b01,2, 1,8'd29,2,0,0,1));
    // reset at col 3 of row 3, then restart from bank 0 address 0
    vecs.push_back(mk(1,1,0,8'd30, 2'b00,3, 0,8'd0,0,0,0,0));
    vecs.push_back(mk(0,1,0,8'd31, 2'b01,0, 0,8'd31,0,0,0,0));
    vecs.push_back(mk(0,1,0,8'd32, 2'b01,1, 0,8'd32,1,0,0,0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
